// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers for the E stage.
// The result is formed from the latched operands and becomes visible only on the commit edge.
module mdu_hilo #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;

    logic [2*WIDTH-1:0] ext_a_s, ext_b_s, prod_s, acc_s, res_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, den_s, quo_mag_s, rem_mag_s, quo_s, rem_s;
    logic               neg_quo_s, neg_rem_s;

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Datapath: one 2W multiplier on extended operands, and a magnitude divider with sign fix-up.
    always_comb begin
        ext_a_s   = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
        ext_b_s   = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_s    = ext_a_s * ext_b_s;
        acc_s     = {hi_q, lo_q};
        mag_a_s   = (!op_q[0] && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
        mag_b_s   = (!op_q[0] && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
        den_s     = (b_q == '0) ? WIDTH'(1) : mag_b_s;
        quo_mag_s = mag_a_s / den_s;
        rem_mag_s = mag_a_s % den_s;
        neg_quo_s = !op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_s = !op_q[0] && a_q[WIDTH-1];
        quo_s     = neg_quo_s ? (~quo_mag_s + WIDTH'(1)) : quo_mag_s;
        rem_s     = neg_rem_s ? (~rem_mag_s + WIDTH'(1)) : rem_mag_s;
        res_s     = acc_s;
        case (op_q)
            3'b000, 3'b001: res_s = prod_s;
            3'b010, 3'b011: begin
                // A zero divisor leaves HI/LO untouched.
                if (b_q != '0) begin
                    res_s = {rem_s, quo_s};
                end else begin
                    res_s = acc_s;
                end
            end
            3'b100, 3'b101: res_s = acc_s + prod_s;
            3'b110, 3'b111: res_s = acc_s - prod_s;
            default:        res_s = acc_s;
        endcase
    end

    // Next-state: launch, countdown, commit, flush and mthi/mtlo writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (start) begin
                    op_d    = md_op;
                    a_d     = rs_val;
                    b_d     = rt_val;
                    cnt_d   = (md_op[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = BUSY;
                end else if (hilo_we) begin
                    if (hilo_sel) begin
                        lo_d = rs_val;
                    end else begin
                        hi_d = rs_val;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CW'(1)) begin
                    hi_d    = res_s[2*WIDTH-1:WIDTH];
                    lo_d    = res_s[WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == BUSY);
    end

    // State, operand and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected {HI,LO} queued at launch, compared when busy drops.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'b000;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] rt_val = 32'h0;
    logic        hilo_we = 1'b0;
    logic        hilo_sel = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [63:0] m_hilo = 64'h0;

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb, q, r;
        logic [63:0] up, sp;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        up = {32'd0, a} * {32'd0, b};
        sp = 64'(sa * sb);
        case (op)
            3'd0: return sp;
            3'd1: return up;
            3'd2: begin
                if (b == 32'd0) return acc;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: return (b == 32'd0) ? acc : {a % b, a / b};
            3'd4: return acc + sp;
            3'd5: return acc + up;
            3'd6: return acc - sp;
            default: return acc - up;
        endcase
    endfunction

    task automatic mt(input logic sel, input logic [31:0] v);
        @(negedge clk);
        hilo_we = 1'b1; hilo_sel = sel; rs_val = v;
        @(negedge clk);
        hilo_we = 1'b0;
        if (sel) m_hilo[31:0] = v; else m_hilo[63:32] = v;
        chk("mthilo", {hi, lo}, m_hilo);
    endtask

    // mode: 0 normal, 1 start/hilo_we poked while busy, 2 flush in busy cycle 3, 3 hilo_we with start
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int mode);
        int n;
        int n_exp;
        n_exp = (mode == 2) ? 3 : ((op[2:1] == 2'b01) ? 10 : 5);
        @(negedge clk);
        md_op = op; rs_val = a; rt_val = b; start = 1'b1;
        if (mode == 3) begin hilo_we = 1'b1; hilo_sel = 1'b0; end
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (mode == 2 && n == 3) flush = 1'b1;
            if (mode == 1 && n == 2) begin
                start = 1'b1; hilo_we = 1'b1; hilo_sel = 1'b1;
                md_op = 3'b011; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1;
            end
            @(negedge clk);
            flush = 1'b0; start = 1'b0; hilo_we = 1'b0;
        end
        chk("busy_cycles", 64'(n), 64'(n_exp));
        chk("result", {hi, lo}, sb_q.pop_front());
        m_hilo = exp;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        #3;
        chk("reset_state", {31'd0, busy, hi, lo}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 0);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(3'b011, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);

        mt(1'b1, 32'hFFFF_FFFF);
        mt(1'b0, 32'h0);
        run_op(3'b100, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 0);
        mt(1'b1, 32'h0);
        mt(1'b0, 32'h0);
        run_op(3'b110, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        mt(1'b0, 32'h11);
        mt(1'b1, 32'h22);
        run_op(3'b010, 32'd100, 32'd7, 64'h0000_0011_0000_0022, 2);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; hilo_we = 1'b1; hilo_sel = 1'b1;
        md_op = 3'b000; rs_val = 32'h5555; rt_val = 32'h2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; hilo_we = 1'b0;
        chk("flush_idle_busy", {63'd0, busy}, 64'h0);
        chk("flush_idle_hilo", {hi, lo}, m_hilo);
        @(negedge clk);
        chk("flush_idle_busy2", {63'd0, busy}, 64'h0);

        mt(1'b0, 32'h1234);
        chk("mthi_lo_kept", {32'd0, lo}, 64'h22);
        run_op(3'b000, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1);
        run_op(3'b100, 32'h0000_ABCD, 32'd0, 64'h0000_0000_0000_002A, 3);

        @(negedge clk);
        md_op = 3'b000; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_pre_reset", {63'd0, busy}, 64'h1);
        #2 reset = 1'b1;
        #1 chk("reset_midop", {31'd0, busy, hi, lo}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        m_hilo = 64'h0;
        run_op(3'b000, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 0);

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(7));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            run_op(rop, ra, rb, model(rop, ra, rb, m_hilo), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
